// File: rtl/alu_uart_interface.sv
// alu_uart_interface: gathers A, B and opcode bytes from UART RX, drives the ALU, then sends the result over UART TX.
module alu_uart_interface #(
  parameter int N    = 8,
  parameter int NSel = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_rx_data,
  input  logic            i_rx_done,
  input  logic            i_tx_done,
  input  logic [N-1:0]    i_alu_result,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic [N-1:0]    o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy
);
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, LATCH, SEND, WAIT_TX} state_t;
  state_t          state_q;
  logic [N-1:0]    a_q, b_q, tx_q;
  logic [NSel-1:0] op_q;
  logic            start_q, busy_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        WAIT_A: if (i_rx_done) begin
          a_q     <= i_rx_data;
          state_q <= WAIT_B;
        end
        WAIT_B: if (i_rx_done) begin
          b_q     <= i_rx_data;
          state_q <= WAIT_OP;
        end
        WAIT_OP: if (i_rx_done) begin
          op_q    <= i_rx_data[NSel-1:0];
          busy_q  <= 1'b1;
          state_q <= LATCH;
        end
        LATCH: begin
          tx_q    <= i_alu_result;
          start_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: state_q <= WAIT_TX;
        WAIT_TX: if (i_tx_done) begin
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
      endcase
    end
  end
  assign o_alu_A    = a_q;
  assign o_alu_B    = b_q;
  assign o_alu_Op   = op_q;
  assign o_tx_data  = tx_q;
  assign o_tx_start = start_q;
  assign o_busy     = busy_q;
endmodule

// File: tb/tb_alu_uart_interface.sv
// tb_alu_uart_interface: frame-level model of the sequencer plus directed literal checks.
module tb_alu_uart_interface;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_A, o_alu_B, o_tx_data;
  logic [5:0] o_alu_Op;
  logic       o_tx_start, o_busy;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] m_a = '0, m_b = '0, m_tx = '0;
  logic [5:0] m_op = '0;
  int         m_cnt = 0;
  int         m_age = 0;
  logic       m_busy = 1'b0;
  alu_uart_interface #(.N(8), .NSel(6)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_alu_result(i_alu_result), .o_alu_A(o_alu_A),
    .o_alu_B(o_alu_B), .o_alu_Op(o_alu_Op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   alu = a + b;
      6'h22:   alu = a - b;
      6'h24:   alu = a & b;
      6'h25:   alu = a | b;
      6'h26:   alu = a ^ b;
      6'h27:   alu = ~(a | b);
      6'h03:   alu = $signed(a) >>> b;
      6'h02:   alu = a >> b;
      default: alu = 8'h00;
    endcase
  endfunction
  always_comb i_alu_result = alu(o_alu_A, o_alu_B, o_alu_Op);
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Frame-level view: bytes fill slots 0..2; after the opcode the block is busy,
  // the result appears one edge later together with the single start pulse.
  task automatic model_update();
    if (!i_rst_n) begin
      m_a = '0; m_b = '0; m_op = '0; m_tx = '0;
      m_cnt = 0; m_busy = 1'b0; m_age = 0;
    end else if (m_busy) begin
      if (m_age == 0) m_tx = alu(m_a, m_b, m_op);
      if (m_age >= 2 && i_tx_done) m_busy = 1'b0;
      else m_age = (m_age >= 2) ? 2 : m_age + 1;
    end else if (i_rx_done) begin
      if (m_cnt == 0) m_a = i_rx_data;
      else if (m_cnt == 1) m_b = i_rx_data;
      else begin
        m_op = i_rx_data[5:0];
        m_busy = 1'b1;
        m_age = 0;
      end
      m_cnt = (m_cnt + 1) % 3;
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    model_update();
    #1;
    chk("model alu_A", o_alu_A, m_a);
    chk("model alu_B", o_alu_B, m_b);
    chk("model alu_Op", {2'b0, o_alu_Op}, {2'b0, m_op});
    chk("model tx_data", o_tx_data, m_tx);
    chk("model tx_start", {7'b0, o_tx_start}, {7'b0, m_busy && m_age == 1});
    chk("model busy", {7'b0, o_busy}, {7'b0, m_busy});
  endtask
  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    i_rx_data = 8'h5A;
  endtask
  // Leaves the bench in the SEND cycle: opcode edge, then LATCH edge.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rx(a); step();
    rx(b); step();
    rx(op); step();
  endtask
  task automatic tx_done_pulse();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask
  task automatic finish_tx();
    step(); step();
    tx_done_pulse();
    step();
  endtask
  initial begin
    step(); step();
    chk("reset tx_data", o_tx_data, 8'h00);
    chk("reset busy", {7'b0, o_busy}, 8'h00);
    i_rst_n = 1'b1;
    step();
    frame(8'h05, 8'h03, 8'h20);
    chk("t1 A", o_alu_A, 8'h05);
    chk("t1 B", o_alu_B, 8'h03);
    chk("t1 Op", {2'b0, o_alu_Op}, 8'h20);
    chk("t1 start at +2", {7'b0, o_tx_start}, 8'h01);
    chk("t1 tx", o_tx_data, 8'h08);
    step();
    chk("t1 start single", {7'b0, o_tx_start}, 8'h00);
    finish_tx();
    chk("t1 idle busy", {7'b0, o_busy}, 8'h00);
    frame(8'h03, 8'h05, 8'h22); chk("t2 sub", o_tx_data, 8'hFE); finish_tx();
    frame(8'h80, 8'h01, 8'h03); chk("t2 sra", o_tx_data, 8'hC0); finish_tx();
    frame(8'h80, 8'h01, 8'h02); chk("t2 srl", o_tx_data, 8'h40); finish_tx();
    frame(8'hF0, 8'h3C, 8'hE4);
    chk("t3 op trunc", {2'b0, o_alu_Op}, 8'h24);
    chk("t3 and", o_tx_data, 8'h30);
    finish_tx();
    frame(8'hF0, 8'h3C, 8'h3F); chk("t3 undef", o_tx_data, 8'h00); finish_tx();
    frame(8'h05, 8'h03, 8'h20);
    i_tx_done = 1'b1; step(); i_tx_done = 1'b0;
    chk("t4 done in SEND ignored", {7'b0, o_busy}, 8'h01);
    rx(8'hAA); step();
    chk("t4 drop A", o_alu_A, 8'h05);
    chk("t4 drop busy", {7'b0, o_busy}, 8'h01);
    tx_done_pulse(); step();
    frame(8'h01, 8'h01, 8'h20); chk("t4 next", o_tx_data, 8'h02); finish_tx();
    tx_done_pulse(); step();
    chk("t4 spurious done", {7'b0, o_busy}, 8'h00);
    rx(8'h11); step(); rx(8'h22); step();
    i_rst_n = 1'b0; step(); i_rst_n = 1'b1;
    chk("t5 rst A", o_alu_A, 8'h00);
    chk("t5 rst B", o_alu_B, 8'h00);
    chk("t5 rst tx", o_tx_data, 8'h00);
    frame(8'h07, 8'h01, 8'h20);
    chk("t5 result", o_tx_data, 8'h08);
    chk("t5 B fresh", o_alu_B, 8'h01);
    step(); step();
    chk("t6 pre tx", o_tx_data, 8'h08);
    i_rst_n = 1'b0; step(); i_rst_n = 1'b1;
    chk("t6 tx cleared", o_tx_data, 8'h00);
    chk("t6 busy cleared", {7'b0, o_busy}, 8'h00);
    step();
    chk("t6 no start", {7'b0, o_tx_start}, 8'h00);
    tx_done_pulse(); step();
    chk("t6 done ignored", {7'b0, o_busy}, 8'h00);
    frame(8'h26, 8'h0F, 8'h26); chk("t6 xor", o_tx_data, 8'h29); finish_tx();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Sequencing stage directly upstream of the ALU, and between the UART receiver and transmitter.
- Collects three bytes from the UART RX path, in order: operand A, operand B, opcode.
- Drives the combinational ALU with registered operands and opcode, then captures the ALU result.
- Hands the result to the UART TX path with a one-cycle start pulse and waits for TX completion before accepting the next frame.

Parameters:
- N, 8, data width of the UART bytes, the ALU operands and the ALU result.
- NSel, 6, ALU opcode width; must satisfy NSel <= N.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_rx_data  input  N  byte from the UART receiver; valid only in the cycle i_rx_done=1.
- i_rx_done  input  1  single-cycle pulse: a received byte is present on i_rx_data.
- i_tx_done  input  1  single-cycle pulse: the UART transmitter has finished sending a byte.
- i_alu_result  input  N  combinational result from the ALU.
- o_alu_A  output  N  registered operand A to the ALU.
- o_alu_B  output  N  registered operand B to the ALU.
- o_alu_Op  output  NSel  registered ALU opcode.
- o_tx_data  output  N  registered byte for the UART transmitter.
- o_tx_start  output  1  single-cycle pulse requesting transmission of o_tx_data.
- o_busy  output  1  1 while in LATCH, SEND or WAIT_TX; registered.

Behaviour:
- Reset
  - When i_rst_n=0 at a rising edge: state=WAIT_A.
  - o_alu_A, o_alu_B, o_alu_Op and o_tx_data are all set to 0.
  - o_tx_start=0 and o_busy=0.
  - Reset has priority over every other event, in every state, including mid-frame and while waiting for TX.
  - A partially received frame is discarded.
- State machine: one-hot or binary encoding, implementer's choice. States: WAIT_A, WAIT_B, WAIT_OP, LATCH, SEND, WAIT_TX.
  - WAIT_A: on i_rx_done=1, o_alu_A <= i_rx_data, go to WAIT_B. Otherwise hold.
  - WAIT_B: on i_rx_done=1, o_alu_B <= i_rx_data, go to WAIT_OP.
  - WAIT_OP: on i_rx_done=1, o_alu_Op <= i_rx_data[NSel-1:0], go to LATCH. Upper N-NSel bits are ignored.
  - LATCH: the ALU now sees the final A, B and Op. o_tx_data <= i_alu_result, go to SEND. No condition.
  - SEND: o_tx_start=1 for exactly this one cycle, go to WAIT_TX.
  - WAIT_TX: on i_tx_done=1, go to WAIT_A.
- Timing
  - o_tx_start is asserted in the 2nd cycle after the edge that captured the opcode.
  - Latency from the opcode byte's i_rx_done edge to o_tx_start high: 2 clocks.
- Byte dropping
  - i_rx_done in LATCH, SEND or WAIT_TX is ignored; the byte is dropped and no register changes.
  - The next frame starts with the first i_rx_done seen in WAIT_A.
- Spurious completion
  - i_tx_done outside WAIT_TX is ignored.
  - i_tx_done in the same cycle as o_tx_start (i.e. in SEND) is ignored.
- Register hold
  - o_alu_A, o_alu_B and o_alu_Op hold their values until overwritten by the next frame.
  - o_tx_data holds until the next LATCH.
- Arithmetic: no width conversion in this block. Bytes pass through unmodified, except the opcode truncation above.
- o_busy is 1 exactly when the state is LATCH, SEND or WAIT_TX.
- There is no timeout: the block waits indefinitely in any WAIT_* state.

Test Plan:
1. Reset, then bytes 0x05, 0x03, 0x20 on i_rx_done pulses.
   - Required: o_alu_A=0x05, o_alu_B=0x03, o_alu_Op=0x20.
   - Required: o_tx_start pulses once, 2 clocks after the opcode pulse, with o_tx_data=0x08.
   - After i_tx_done: o_busy=0, state=WAIT_A.
2. Bytes 0x03, 0x05, 0x22.
   - Required: o_tx_data=0xFE.
   - Then bytes 0x80, 0x01, 0x03: o_tx_data=0xC0 (SRA).
   - Then bytes 0x80, 0x01, 0x02: o_tx_data=0x40 (SRL).
3. Opcode byte 0xE4 with A=0xF0, B=0x3C.
   - Required: o_alu_Op=0x24 and o_tx_data=0x30.
   - Undefined opcode 0x3F: o_tx_data=0x00.
4. Complete a frame, then pulse i_rx_done with 0xAA during WAIT_TX, then pulse i_tx_done.
   - Required: 0xAA is dropped; the operands are unchanged.
   - The next frame 0x01, 0x01, 0x20 yields 0x02.
   - Pulse i_tx_done while in WAIT_A: no state change.
5. Send A=0x11, B=0x22, then drive i_rst_n=0 for one cycle, then send 0x07, 0x01, 0x20.
   - Required: all outputs 0 after reset.
   - The result is 0x08; 0x11 and 0x22 are not reused.
6. Assert i_rst_n=0 during WAIT_TX with o_tx_data=0x08.
   - Required: o_tx_data=0, o_busy=0, and no o_tx_start pulse.
   - A subsequent i_tx_done is ignored.
